// File: rtl/crc8_framer.sv
// CRC-8 framer: passes a byte stream through a one-deep output register and
// appends a CRC-8 (poly 0x07, MSB-first) byte after the last payload byte of each frame.

module crc8_step (
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);
    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        crc_out = c;
    end
endmodule

module crc8_framer #(
    parameter logic [7:0] INIT   = 8'h00,
    parameter logic [7:0] XOROUT = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_s_data,
    input  logic       i_s_valid,
    input  logic       i_s_last,
    output logic       o_s_ready,
    output logic [7:0] o_m_data,
    output logic       o_m_valid,
    output logic       o_m_last,
    input  logic       i_m_ready,
    output logic       o_busy
);
    typedef enum logic {
        S_DATA,
        S_CRC
    } state_t;

    state_t     state, state_d;
    logic [7:0] crc_reg, crc_d, crc_next;
    logic [7:0] m_data_d;
    logic       m_valid_d, m_last_d, busy_d;
    logic       stage_free, s_xfer, crc_done;

    crc8_step u_step (
        .crc_in (crc_reg),
        .data   (i_s_data),
        .crc_out(crc_next)
    );

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        stage_free = !o_m_valid || i_m_ready;
        o_s_ready  = !i_rst && (state == S_DATA) && stage_free;
        s_xfer     = i_s_valid && o_s_ready;
        crc_done   = o_m_valid && o_m_last && i_m_ready;

        state_d   = state;
        crc_d     = crc_reg;
        m_data_d  = o_m_data;
        m_valid_d = o_m_valid;
        m_last_d  = o_m_last;
        busy_d    = o_busy;

        if (stage_free) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (s_xfer) begin
                m_data_d  = i_s_data;
                m_valid_d = 1'b1;
                crc_d     = crc_next;
                if (i_s_last) state_d = S_CRC;
            end else if (state == S_CRC) begin
                m_data_d  = crc_reg ^ XOROUT;
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                crc_d     = INIT;
                state_d   = S_DATA;
            end
        end

        // A new frame's first byte may be accepted while the previous CRC drains.
        if (crc_done) busy_d = 1'b0;
        if (s_xfer)   busy_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_DATA;
            crc_reg   <= INIT;
            o_m_data  <= 8'h00;
            o_m_valid <= 1'b0;
            o_m_last  <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            state     <= state_d;
            crc_reg   <= crc_d;
            o_m_data  <= m_data_d;
            o_m_valid <= m_valid_d;
            o_m_last  <= m_last_d;
            o_busy    <= busy_d;
        end
    end
endmodule

// File: tb/tb_crc8_framer.sv
// Self-checking bench for crc8_framer: directed vectors plus randomized frames
// with random backpressure, scored against a bit-serial CRC reference model.

module tb_crc8_framer;
    localparam logic [7:0] INIT   = 8'h00;
    localparam logic [7:0] XOROUT = 8'h00;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_s_data = 8'h00;
    logic       i_s_valid = 1'b0;
    logic       i_s_last = 1'b0;
    logic       o_s_ready;
    logic [7:0] o_m_data;
    logic       o_m_valid;
    logic       o_m_last;
    logic       i_m_ready = 1'b0;
    logic       o_busy;

    crc8_framer #(.INIT(INIT), .XOROUT(XOROUT)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_s_data (i_s_data),
        .i_s_valid(i_s_valid),
        .i_s_last (i_s_last),
        .o_s_ready(o_s_ready),
        .o_m_data (o_m_data),
        .o_m_valid(o_m_valid),
        .o_m_last (o_m_last),
        .i_m_ready(i_m_ready),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       last;
        logic [7:0] data;
        int         cyc;
    } rx_t;

    rx_t        rx_log[$];
    logic [8:0] exp_q[$];
    logic [7:0] frame_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         model_open = 0;
    bit         crc_pending = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    bit         rnd_on = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference CRC: polynomial division one message bit at a time, MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [7:0] r;
        logic       fb;
        r = INIT;
        for (int b = 0; b < msg.size(); b++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = r[7] ^ msg[b][k];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r ^ XOROUT;
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        logic [8:0] e;
        if (i_rst) begin
            exp_q.delete();
            frame_q.delete();
            model_open  = 0;
            crc_pending = 0;
            prev_stall  = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", o_m_valid, 1);
                check("hold_data", o_m_data, prev_data);
                check("hold_last", o_m_last, prev_last);
            end
            check("busy", o_busy, model_open);
            if (crc_pending && o_m_valid && o_m_last) crc_pending = 0;
            if (crc_pending) check("sready_crc_pending", o_s_ready, 0);
            if (o_m_valid && i_m_ready) begin
                rx_log.push_back('{last: o_m_last, data: o_m_data, cyc: cyc});
                if (exp_q.size() == 0) begin
                    check("out_extra_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", {o_m_last, o_m_data}, e);
                    if (e[8]) model_open = 0;
                end
            end
            if (i_s_valid && o_s_ready) begin
                frame_q.push_back(i_s_data);
                exp_q.push_back({1'b0, i_s_data});
                model_open = 1;
                if (i_s_last) begin
                    exp_q.push_back({1'b1, ref_crc(frame_q)});
                    frame_q.delete();
                    crc_pending = 1;
                end
            end
            prev_stall = o_m_valid && !i_m_ready;
            prev_data  = o_m_data;
            prev_last  = o_m_last;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic acc;
        acc       = 1'b0;
        i_s_valid = 1'b1;
        i_s_data  = d;
        i_s_last  = l;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge i_clk);
            acc = o_s_ready;
            if (acc) acc_cyc = cyc;
            tick();
        end
        check("accepted", acc, 1);
        i_s_valid = 1'b0;
        i_s_data  = 8'($urandom);
        i_s_last  = 1'($urandom);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
        check("drain", exp_q.size(), 0);
        tick();
    endtask

    task automatic check_log(input string tag, input logic [8:0] exp[$]);
        check({tag, "_len"}, rx_log.size(), exp.size());
        for (int i = 0; i < rx_log.size() && i < exp.size(); i++)
            check(tag, {rx_log[i].last, rx_log[i].data}, exp[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [8:0] e[$];
        int a1, a2;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_sready", o_s_ready, 0);
        check("rst_valid", o_m_valid, 0);
        check("rst_last", o_m_last, 0);
        check("rst_data", o_m_data, 0);
        check("rst_busy", o_busy, 0);
        tick();
        i_rst     = 1'b0;
        i_m_ready = 1'b1;
        tick();

        // Single-byte frame: payload then CRC on consecutive cycles
        rx_log.delete();
        send_byte(8'h01, 1'b1);
        a1 = acc_cyc;
        wait_drain();
        e = '{9'h001, 9'h107};
        check_log("t_single", e);
        if (rx_log.size() >= 2) begin
            check("t_single_latency", rx_log[0].cyc - a1, 1);
            check("t_single_gap", rx_log[1].cyc - rx_log[0].cyc, 1);
        end

        // Two-byte frame
        rx_log.delete();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b1);
        wait_drain();
        e = '{9'h001, 9'h002, 9'h11B};
        check_log("t_two", e);

        // Check string "123456789"
        rx_log.delete();
        e.delete();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h31 + 8'(i), i == 8);
            e.push_back({1'b0, 8'h31 + 8'(i)});
        end
        e.push_back(9'h1F4);
        wait_drain();
        check_log("t_check", e);

        // CRC byte held under backpressure
        rx_log.delete();
        send_byte(8'h01, 1'b1);
        tick();
        i_m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("bp_valid", o_m_valid, 1);
            check("bp_data", o_m_data, 8'h07);
            check("bp_last", o_m_last, 1);
            check("bp_sready", o_s_ready, 0);
            tick();
        end
        i_m_ready = 1'b1;
        wait_drain();
        e = '{9'h001, 9'h107};
        check_log("t_bp", e);

        // Back-to-back single-byte frames
        rx_log.delete();
        send_byte(8'h01, 1'b1);
        a1 = acc_cyc;
        send_byte(8'h00, 1'b1);
        a2 = acc_cyc;
        wait_drain();
        check("b2b_idle_gap", a2 - a1, 2);
        e = '{9'h001, 9'h107, 9'h000, 9'h100};
        check_log("t_b2b", e);

        // Reset mid-frame discards the partial frame
        rx_log.delete();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_sready", o_s_ready, 0);
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst_valid", o_m_valid, 0);
        check("midrst_busy", o_busy, 0);
        tick();
        repeat (3) tick();
        e = '{9'h031};
        check_log("t_midrst_pre", e);
        rx_log.delete();
        e.delete();
        for (int i = 0; i < 9; i++) begin
            send_byte(8'h31 + 8'(i), i == 8);
            e.push_back({1'b0, 8'h31 + 8'(i)});
        end
        e.push_back(9'h1F4);
        wait_drain();
        check_log("t_midrst_post", e);

        // Randomized frames with random gaps and random downstream backpressure
        rnd_on = 1;
        fork
            begin
                while (rnd_on) begin
                    i_m_ready = ($urandom_range(0, 99) < 65);
                    tick();
                end
            end
            begin
                for (int f = 0; f < 30; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_byte(8'($urandom), i == len - 1);
                    end
                end
                rnd_on = 0;
            end
        join
        i_m_ready = 1'b1;
        wait_drain();
        check("final_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/crc8_framer.md
CRC8_FRAMER -- requirements
Module: crc8_framer

Interface
REQ-001 Parameter INIT, default 8'h00, SHALL be the CRC register value at frame start.
REQ-002 Parameter XOROUT, default 8'h00, SHALL be XORed into the final CRC before emission.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_s_data  input  8  SHALL carry the upstream payload byte.
REQ-006 i_s_valid  input  1  SHALL mark an upstream byte as valid.
REQ-007 i_s_last  input  1  SHALL mark the upstream byte as the last payload byte of its frame.
REQ-008 o_s_ready  output  1  SHALL signal that the block accepts an upstream byte this cycle.
REQ-009 o_m_data  output  8  SHALL carry the downstream byte: either a payload byte or the CRC byte.
REQ-010 o_m_valid  output  1  SHALL mark a downstream byte as valid.
REQ-011 o_m_last  output  1  SHALL mark the appended CRC byte, which is the last downstream byte of a frame.
REQ-012 i_m_ready  input  1  SHALL signal that downstream accepts the byte this cycle.
REQ-013 o_busy  output  1  SHALL be high while a frame is open: first byte accepted, CRC byte not yet accepted downstream.

Function
REQ-014 A transfer on either port SHALL occur only in a cycle where valid and ready are both high.
REQ-015 CRC stepping SHALL use the codebase combinational crc8 stepping module: x^8+x^2+x+1 (0x07), left shift, 8-bit input word, no reflection.
REQ-016 The stepping SHALL compute crc_next = crc8(crc_reg, i_s_data) once per accepted upstream byte.
REQ-017 The FSM SHALL have two states: S_DATA (passing payload) and S_CRC (CRC byte pending).
REQ-018 The output stage SHALL be a single register holding o_m_data, o_m_valid and o_m_last; it is free when o_m_valid=0 or i_m_ready=1.
REQ-019 In S_DATA, o_s_ready SHALL equal the "output stage free" condition; o_s_ready SHALL be 0 in S_CRC.
REQ-020 On an upstream transfer, the block SHALL:
  - load o_m_data=i_s_data, o_m_valid=1, o_m_last=0;
  - set crc_reg=crc_next;
  - move to S_CRC if i_s_last=1.
REQ-021 In S_CRC with the output stage free, the block SHALL:
  - load o_m_data=crc_reg^XOROUT, o_m_valid=1, o_m_last=1;
  - set crc_reg=INIT;
  - return to S_DATA.
REQ-022 When the output stage is free and nothing is loaded, o_m_valid SHALL clear on the next edge.
REQ-023 Latency SHALL be 1 cycle from upstream transfer to the byte appearing on o_m_data.
REQ-024 The CRC byte SHALL appear the cycle after the last payload byte is accepted if downstream drains; otherwise it appears once the stage frees.
REQ-025 Peak throughput SHALL be 1 byte/cycle with i_m_ready held high.
REQ-026 Frame cost SHALL be N payload cycles + 1 CRC cycle.
REQ-027 While o_m_valid=1 and i_m_ready=0, o_m_data, o_m_valid and o_m_last SHALL hold stable.
REQ-028 The CRC byte SHALL always be emitted, even when i_m_ready is low when the frame ends.
REQ-029 A single-byte frame (i_s_valid=1, i_s_last=1 on the first byte) SHALL produce exactly 2 downstream bytes.
REQ-030 No upstream byte SHALL be accepted in the cycle the CRC byte is loaded; the next frame's first byte is accepted no earlier than the following cycle.
REQ-031 o_busy SHALL rise on the first accepted byte of a frame and fall in the cycle the CRC byte transfers downstream.
REQ-032 i_s_data and i_s_last SHALL be ignored when no upstream transfer occurs.

Reset
REQ-033 While i_rst=1, the block SHALL set: state=S_DATA, crc_reg=INIT, o_m_valid=0, o_m_last=0, o_m_data=8'h00, o_busy=0.
REQ-034 While i_rst=1, o_s_ready SHALL be 0.
REQ-035 Reset mid-frame SHALL discard the partial frame and any pending CRC byte; the first byte after reset starts a new frame from INIT.

Verification
REQ-036 Single byte 0x01 with last, i_m_ready=1 -> downstream 0x01 (last=0), then 0x07 (last=1) on consecutive cycles.
REQ-037 Bytes 0x01, 0x02 (last on 0x02) -> downstream 0x01, 0x02, 0x1B (last=1).
REQ-038 ASCII "123456789" (0x31..0x39), last on 0x39 -> 9 bytes passed unchanged, then CRC 0xF4 with last=1.
REQ-039 Backpressure: i_m_ready=0 for 3 cycles while CRC is pending:
  - o_m_data, o_m_valid and o_m_last stay stable;
  - o_s_ready=0;
  - CRC 0x07 transfers once i_m_ready=1.
REQ-040 Back-to-back frames {0x01,last} then {0x00,last}:
  - downstream sequence 0x01, 0x07, 0x00, 0x00;
  - crc_reg restarts from INIT for the second frame;
  - one idle upstream cycle after each CRC load.
REQ-041 i_rst pulsed after 0x31, 0x32 are accepted:
  - o_m_valid=0 next cycle and no CRC is emitted;
  - a following frame "123456789" yields 0xF4.
